turbosound_bus_n: RTL and testbench

Bus front-end for an N-chip Turbosound-FM array. It synchronises the AY-style bus (BDIR/BC/DI) into CLK and decodes the chip-select command byte. Register writes are queued in a FIFO and replayed to the selected YM2203 core, paced by a CE-counted gap so the chip's post-write busy time is always respected. It sits between the CPU port decoder and the per-chip YM2203 instances and generalises the 2-chip controller to 1–4 chips.

---
 rtl/turbosound_pkg.sv | 22 ++
 rtl/ts_wr_fifo.sv | 52 +++++
 rtl/turbosound_bus_n.sv | 211 +++++++++++++++++++++
 tb/tb_turbosound_bus_n.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turbosound_pkg.sv
// Shared definitions for the Turbosound-FM bus front-end.
// Holds the command-byte prefixes, the chip-index width, the layout of one
// queued register write and the issue FSM state encoding.
package turbosound_pkg;

    localparam logic [4:0] CMD_TS     = 5'b11111;
    localparam logic [4:0] CMD_TS_EXT = 5'b11101;
    localparam int         IDX_W      = 2;

    // One queued register write: target chip, YM A0 line, write data.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             a0;
        logic [7:0]       data;
    } ts_entry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STROBE = 1'b1
    } ts_state_e;

endpackage

// File: rtl/ts_wr_fifo.sv
// Synchronous write queue for the Turbosound bus front-end.
// Ports:
//   CLK, RESET_s      clock, async active-high reset (flushes the queue)
//   push_i, data_i    enqueue request and entry; dropped when full
//   pop_i             dequeue request; ignored when empty
//   data_o            entry at the head of the queue
//   full_o, empty_o   occupancy flags
module ts_wr_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_s,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/turbosound_bus_n.sv
// Bus front-end for an N-chip Turbosound-FM array.
// Synchronises the AY-style bus, decodes chip-select commands, queues
// register writes and replays them to the chips with a CE-counted gap.
// Ports:
//   CLK, RESET_s         clock, async active-high reset
//   CE                   YM master clock enable (paces the post-write gap)
//   BDIR, BC, DI         asynchronous AY-style bus
//   DO                   readback of the selected chip
//   chip_dout            per-chip readback, chip i at [8i+7:8i]
//   chip_cs_n            per-chip select, active low
//   chip_wr_n            shared write strobe, one CLK wide
//   chip_addr, chip_din  shared A0 and write data
//   fm_ena               FM output enable
//   busy                 queue non-empty or gap still running
//   ovf                  sticky: a write was dropped on a full queue
module turbosound_bus_n
    import turbosound_pkg::*;
#(
    parameter int NUM_CHIPS   = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int WR_GAP      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET_s,
    input  logic                   CE,
    input  logic                   BDIR,
    input  logic                   BC,
    input  logic [7:0]             DI,
    output logic [7:0]             DO,
    input  logic [8*NUM_CHIPS-1:0] chip_dout,
    output logic [NUM_CHIPS-1:0]   chip_cs_n,
    output logic                   chip_wr_n,
    output logic                   chip_addr,
    output logic [7:0]             chip_din,
    output logic                   fm_ena,
    output logic                   busy,
    output logic                   ovf
);

    localparam int GAP_W = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

    logic [9:0]       sync_q [SYNC_STAGES];
    logic             bdir_prev_q;
    logic             s_bdir, s_bc, bus_event;
    logic [7:0]       s_di;

    logic [IDX_W-1:0] sel_q, sel_d;
    logic             stat_sel_q, stat_sel_d;
    logic             fm_ena_q, fm_ena_d;
    logic             acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             push;
    ts_entry_t        push_entry;
    logic             cmd_hit;
    logic [IDX_W-1:0] cmd_idx;

    ts_state_e        state_q, state_d;
    ts_entry_t        issue_q, pop_entry;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             pop;
    logic             fifo_full, fifo_empty;
    logic [$bits(ts_entry_t)-1:0] fifo_dout;

    // Synchroniser flops reset to 0 so releasing reset never looks like a BDIR edge.
    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            bdir_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {BDIR, BC, DI};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            bdir_prev_q <= s_bdir;
        end
    end

    assign s_bdir    = sync_q[SYNC_STAGES-1][9];
    assign s_bc      = sync_q[SYNC_STAGES-1][8];
    assign s_di      = sync_q[SYNC_STAGES-1][7:0];
    assign bus_event = s_bdir && !bdir_prev_q;

    always_comb begin
        sel_d      = sel_q;
        stat_sel_d = stat_sel_q;
        fm_ena_d   = fm_ena_q;
        acc_d      = acc_q;
        push       = 1'b0;
        push_entry = '{idx: sel_q, a0: 1'b1, data: s_di};
        cmd_hit    = 1'b0;
        cmd_idx    = '0;
        if (bus_event) begin
            if (s_bc) begin
                if (s_di[7:3] == CMD_TS) begin
                    cmd_hit = 1'b1;
                    cmd_idx = {1'b0, ~s_di[0]};
                end else if (s_di[7:3] == CMD_TS_EXT) begin
                    cmd_hit = 1'b1;
                    cmd_idx = {1'b1, ~s_di[0]};
                end
                if (cmd_hit) begin
                    // Selecting a chip that is not fitted leaves every field alone.
                    if (int'(cmd_idx) < NUM_CHIPS) begin
                        sel_d      = cmd_idx;
                        stat_sel_d = s_di[1];
                        fm_ena_d   = ~s_di[2];
                        acc_d      = 1'b0;
                    end
                end else begin
                    acc_d         = (s_di[7:4] == 4'h0) || fm_ena_q;
                    push          = acc_d;
                    push_entry.a0 = 1'b0;
                end
            end else begin
                push = acc_q;
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q || (push && fifo_full);
        if (cmd_hit && (int'(cmd_idx) < NUM_CHIPS)) ovf_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            sel_q      <= '0;
            stat_sel_q <= 1'b1;
            fm_ena_q   <= 1'b0;
            acc_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            stat_sel_q <= stat_sel_d;
            fm_ena_q   <= fm_ena_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    ts_wr_fifo #(
        .WIDTH ($bits(ts_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET_s (RESET_s),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pop_entry = fifo_dout;

    // Issue FSM: state register.
    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Issue FSM: next state. Popping only from IDLE keeps strobes at least
    // 2 CLK apart even with no gap.
    always_comb begin
        pop     = (state_q == ST_IDLE) && !fifo_empty && (gap_q == '0);
        state_d = pop ? ST_STROBE : ST_IDLE;
    end

    // The gap is loaded with the strobe and only counts CE ticks after it.
    always_comb begin
        gap_d = gap_q;
        if (pop)
            gap_d = GAP_W'(WR_GAP);
        else if ((state_q == ST_IDLE) && CE && (gap_q != '0))
            gap_d = gap_q - 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            gap_q   <= '0;
            issue_q <= '0;
        end else begin
            gap_q <= gap_d;
            if (pop) issue_q <= pop_entry;
        end
    end

    // Issue FSM: outputs.
    always_comb begin
        chip_wr_n = 1'b1;
        chip_addr = stat_sel_q;
        for (int i = 0; i < NUM_CHIPS; i++) chip_cs_n[i] = (sel_q != IDX_W'(i));
        if (state_q == ST_STROBE) begin
            chip_wr_n = 1'b0;
            chip_addr = issue_q.a0;
            for (int i = 0; i < NUM_CHIPS; i++) chip_cs_n[i] = (issue_q.idx != IDX_W'(i));
        end
    end

    always_comb begin
        DO = '0;
        for (int i = 0; i < NUM_CHIPS; i++)
            if (sel_q == IDX_W'(i)) DO = chip_dout[8*i +: 8];
    end

    assign chip_din = issue_q.data;
    assign fm_ena   = fm_ena_q;
    assign busy     = !fifo_empty || (gap_q != '0);
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_turbosound_bus_n.sv
// Directed bench for turbosound_bus_n. Three instances share the bus:
// d (2 chips, depth 8), q (4 chips) and f (FIFO depth 4).
module tb_turbosound_bus_n;

    logic        CLK = 1'b0;
    logic        RESET_s = 1'b1;
    logic        CE = 1'b0;
    logic        BDIR = 1'b0;
    logic        BC = 1'b0;
    logic [7:0]  DI = 8'h00;
    logic        ce_en = 1'b0;

    logic [15:0] dout2 = 16'hB2A1;
    logic [31:0] dout4 = 32'hD4C3B2A1;

    logic [7:0] d_do, q_do, f_do;
    logic [1:0] d_cs_n, f_cs_n;
    logic [3:0] q_cs_n;
    logic       d_wr_n, q_wr_n, f_wr_n;
    logic       d_addr, q_addr, f_addr;
    logic [7:0] d_din, q_din, f_din;
    logic       d_fm, q_fm, f_fm;
    logic       d_busy, q_busy, f_busy;
    logic       d_ovf, q_ovf, f_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] st_q[$];
    int          gap_q[$];
    logic [7:0]  f_st_q[$];
    int          ce_since = 0;

    turbosound_bus_n #(.NUM_CHIPS(2), .FIFO_DEPTH(8), .WR_GAP(24), .SYNC_STAGES(2)) d (
        .CLK(CLK), .RESET_s(RESET_s), .CE(CE), .BDIR(BDIR), .BC(BC), .DI(DI),
        .DO(d_do), .chip_dout(dout2), .chip_cs_n(d_cs_n), .chip_wr_n(d_wr_n),
        .chip_addr(d_addr), .chip_din(d_din), .fm_ena(d_fm), .busy(d_busy), .ovf(d_ovf));

    turbosound_bus_n #(.NUM_CHIPS(4), .FIFO_DEPTH(8), .WR_GAP(24), .SYNC_STAGES(2)) q (
        .CLK(CLK), .RESET_s(RESET_s), .CE(CE), .BDIR(BDIR), .BC(BC), .DI(DI),
        .DO(q_do), .chip_dout(dout4), .chip_cs_n(q_cs_n), .chip_wr_n(q_wr_n),
        .chip_addr(q_addr), .chip_din(q_din), .fm_ena(q_fm), .busy(q_busy), .ovf(q_ovf));

    turbosound_bus_n #(.NUM_CHIPS(2), .FIFO_DEPTH(4), .WR_GAP(24), .SYNC_STAGES(2)) f (
        .CLK(CLK), .RESET_s(RESET_s), .CE(CE), .BDIR(BDIR), .BC(BC), .DI(DI),
        .DO(f_do), .chip_dout(dout2), .chip_cs_n(f_cs_n), .chip_wr_n(f_wr_n),
        .chip_addr(f_addr), .chip_din(f_din), .fm_ena(f_fm), .busy(f_busy), .ovf(f_ovf));

    always #5 CLK = ~CLK;

    // CE pulses every 4th CLK while enabled.
    initial begin
        int ce_cnt;
        ce_cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            ce_cnt++;
            CE = ce_en && (ce_cnt % 4 == 0);
        end
    end

    // Strobe recorder: {cs_n, a0, din} plus CE ticks seen since the previous strobe.
    always @(negedge CLK) begin
        if (!RESET_s) begin
            if (!d_wr_n) begin
                st_q.push_back({d_cs_n, d_addr, d_din});
                gap_q.push_back(ce_since);
                ce_since = 0;
            end else if (CE) begin
                ce_since++;
            end
            if (!f_wr_n) f_st_q.push_back(f_din);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic bc, input logic [7:0] data);
        @(posedge CLK); #1;
        BC = bc;
        DI = data;
        @(posedge CLK); #1;
        BDIR = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        BDIR = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int c;
        c = 0;
        while (st_q.size() < n && c < budget) begin
            @(negedge CLK);
            c++;
        end
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        @(negedge CLK); #1;
        while ((d_busy || f_busy) && c < budget) begin
            @(negedge CLK); #1;
            c++;
        end
    endtask

    initial begin
        int   c;
        logic seen;

        // Reset values
        repeat (3) @(posedge CLK);
        #1 RESET_s = 1'b0;
        @(negedge CLK); #1;
        check("rst_cs_n", d_cs_n, 2'b10);
        check("rst_cs_n4", q_cs_n, 4'b1110);
        check("rst_wr_n", d_wr_n, 1'b1);
        check("rst_addr", d_addr, 1'b1);
        check("rst_din", d_din, 8'h00);
        check("rst_fm", d_fm, 1'b0);
        check("rst_busy", d_busy, 1'b0);
        check("rst_ovf", d_ovf, 1'b0);
        check("rst_do", d_do, 8'hA1);

        // 0xFE selects chip1, stat_sel=1, fm_ena=0
        bus_write(1'b1, 8'hFE);
        check("fe_cs_n", d_cs_n, 2'b01);
        check("fe_addr", d_addr, 1'b1);
        check("fe_fm", d_fm, 1'b0);
        check("fe_do", d_do, 8'hB2);
        check("fe_cs_n4", q_cs_n, 4'b1101);

        // 0xEA selects chip3 on the 4-chip array, ignored on the 2-chip one
        bus_write(1'b1, 8'hEA);
        check("ea4_cs_n", q_cs_n, 4'b0111);
        check("ea4_fm", q_fm, 1'b1);
        check("ea4_do", q_do, 8'hD4);
        check("ea2_cs_n", d_cs_n, 2'b01);
        check("ea2_fm", d_fm, 1'b0);
        check("ea2_addr", d_addr, 1'b1);
        check("ea2_do", d_do, 8'hB2);

        // 0xFD: chip0, stat_sel=0, fm_ena=0
        bus_write(1'b1, 8'hFD);
        check("fd_cs_n", d_cs_n, 2'b10);
        check("fd_addr", d_addr, 1'b0);
        check("fd_do", d_do, 8'hA1);

        // Address 0x27 with fm_ena=0 is not accepted, nor is the following data
        bus_write(1'b1, 8'h27);
        bus_write(1'b0, 8'h55);
        check("rej_busy", d_busy, 1'b0);
        check("rej_strobes", st_q.size(), 0);

        // Address 0x07 then data 0x3F
        ce_en = 1'b1;
        bus_write(1'b1, 8'h07);
        bus_write(1'b0, 8'h3F);
        check("aw_busy", d_busy, 1'b1);
        wait_strobes(2, 400);
        check("aw_n", st_q.size(), 2);
        if (st_q.size() >= 2) begin
            check("aw_st0", st_q[0], {2'b10, 1'b0, 8'h07});
            check("aw_st1", st_q[1], {2'b10, 1'b1, 8'h3F});
        end
        wait_idle(400);
        check("aw_idle", d_busy, 1'b0);

        // Five back-to-back data writes, paced by the CE gap
        st_q.delete();
        gap_q.delete();
        bus_write(1'b0, 8'h11);
        bus_write(1'b0, 8'h22);
        bus_write(1'b0, 8'h33);
        bus_write(1'b0, 8'h44);
        bus_write(1'b0, 8'h55);
        check("b2b_busy", d_busy, 1'b1);
        wait_strobes(5, 1000);
        check("b2b_n", st_q.size(), 5);
        for (int i = 0; i < 5 && i < st_q.size(); i++) begin
            check("b2b_data", st_q[i], {2'b10, 1'b1, 8'(8'h11 * (i + 1))});
            if (i > 0) check("b2b_gap", gap_q[i], 24);
        end
        wait_idle(400);
        check("b2b_idle", d_busy, 1'b0);
        check("b2b_tail_gap", ce_since, 24);
        check("b2b_f_ovf", f_ovf, 1'b0);

        // Overflow with CE held low: depth-4 queue drops the sixth write
        ce_en = 1'b0;
        f_st_q.delete();
        bus_write(1'b0, 8'h61);
        bus_write(1'b0, 8'h62);
        bus_write(1'b0, 8'h63);
        bus_write(1'b0, 8'h64);
        bus_write(1'b0, 8'h65);
        bus_write(1'b0, 8'h66);
        check("ovf_f", f_ovf, 1'b1);
        check("ovf_f_busy", f_busy, 1'b1);
        check("ovf_f_n", f_st_q.size(), 1);
        check("ovf_d", d_ovf, 1'b0);
        bus_write(1'b1, 8'hFD);
        check("ovf_clr", f_ovf, 1'b0);
        ce_en = 1'b1;
        wait_idle(1000);
        check("ovf_drain_n", f_st_q.size(), 5);
        for (int i = 0; i < 5 && i < f_st_q.size(); i++)
            check("ovf_drain", f_st_q[i], 8'h61 + 8'(i));
        check("ovf_d_busy", d_busy, 1'b0);

        // Reset during a strobe with 3 entries still queued
        ce_en = 1'b0;
        bus_write(1'b1, 8'h07);
        bus_write(1'b0, 8'h71);
        bus_write(1'b0, 8'h72);
        bus_write(1'b0, 8'h73);
        bus_write(1'b0, 8'h74);
        ce_en = 1'b1;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 300) begin
            @(negedge CLK);
            c++;
            if (!d_wr_n) seen = 1'b1;
        end
        check("rst_mid_strobe", seen, 1'b1);
        check("rst_mid_din", d_din, 8'h71);
        RESET_s = 1'b1;
        #1;
        check("rst_mid_wr_n", d_wr_n, 1'b1);
        check("rst_mid_busy", d_busy, 1'b0);
        st_q.delete();
        repeat (2) @(posedge CLK);
        #1 RESET_s = 1'b0;
        repeat (300) @(posedge CLK);
        @(negedge CLK); #1;
        check("rst_post_n", st_q.size(), 0);
        check("rst_post_busy", d_busy, 1'b0);
        check("rst_post_cs_n", d_cs_n, 2'b10);
        check("rst_post_din", d_din, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
